// File: rtl/md_issue_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_issue_sequencer_pkg
// Description : Shared definitions for the MDU issue/writeback sequencer:
//               register address width and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package md_issue_sequencer_pkg;

  // 16 architectural registers, none hardwired.
  localparam int MD_REG_ADDR_W = 4;

  typedef logic [1:0] md_state_t;

  // Sequencer states.
  localparam md_state_t ST_IDLE    = 2'd0;
  localparam md_state_t ST_RUN     = 2'd1;
  localparam md_state_t ST_WB_WAIT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/md_dep_check.sv
`default_nettype none
// ============================================================================
// Module      : md_dep_check
// Description : Combinational hazard detection of the ID instruction against
//               the single outstanding MDU destination register.
//   i_rs1/i_rs2, i_re1/i_re2 : ID source registers and read enables
//   i_rd, i_we               : ID destination register and write enable
//   i_md_op                  : ID instruction is an MDU op
//   i_flush                  : ID instruction squashed (masks every hazard)
//   i_pend_valid, i_pend_rd  : outstanding MDU destination
//   i_busy                   : sequencer is not IDLE
//   o_raw, o_waw, o_struct   : hazard terms
// Revision    : 1.0 - initial release
// ============================================================================
module md_dep_check
  import md_issue_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = MD_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  input  logic                  i_re1,
  input  logic                  i_re2,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_we,
  input  logic                  i_md_op,
  input  logic                  i_flush,
  input  logic                  i_pend_valid,
  input  logic [REG_ADDR_W-1:0] i_pend_rd,
  input  logic                  i_busy,
  output logic                  o_raw,
  output logic                  o_waw,
  output logic                  o_struct
);

  logic w_src1_hit;
  logic w_src2_hit;
  logic w_dst_hit;

  assign w_src1_hit = i_re1 & (i_rs1 == i_pend_rd);
  assign w_src2_hit = i_re2 & (i_rs2 == i_pend_rd);
  assign w_dst_hit  = i_we  & (i_rd  == i_pend_rd);

  // A squashed instruction never needs to wait, so the flush masks all terms.
  assign o_raw    = !i_flush & i_pend_valid & (w_src1_hit | w_src2_hit);
  assign o_waw    = !i_flush & i_pend_valid & w_dst_hit;
  assign o_struct = !i_flush & i_md_op & i_busy;

endmodule
`default_nettype wire

// File: rtl/md_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : md_issue_sequencer
// Description : Launches MDU operations from ID, tracks the single pending
//               destination register, stalls ID on RAW/WAW/structural
//               hazards and shares the register-file write port between
//               pipeline WB traffic (priority) and the MDU result.
//   clk, rst_n         : clock, asynchronous active-low reset
//   rs1_id..md_op_id   : ID stage instruction fields
//   flush_id           : ID instruction squashed by a taken branch
//   wb_pipe_valid      : pipeline WB writes the register file this cycle
//   md_done            : MDU result ready, held until md_ack
//   md_start, md_ack   : MDU launch / result consumed
//   wb_md_sel/wb_md_rd : write port carries MDU result / its address
//   stall_md, md_busy  : ID stall request / sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
module md_issue_sequencer
  import md_issue_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = MD_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  re1_id,
  input  logic                  re2_id,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic                  we_id,
  input  logic                  md_op_id,
  input  logic                  flush_id,
  input  logic                  wb_pipe_valid,
  input  logic                  md_done,
  output logic                  md_start,
  output logic                  md_ack,
  output logic                  wb_md_sel,
  output logic [REG_ADDR_W-1:0] wb_md_rd,
  output logic                  stall_md,
  output logic                  md_busy
);

  md_state_t             r_state;
  md_state_t             w_state_nxt;
  logic                  r_pend_valid;
  logic [REG_ADDR_W-1:0] r_pend_rd;

  logic w_raw;
  logic w_waw;
  logic w_struct;
  logic w_drain;
  logic w_issue;
  logic w_ack;

  md_dep_check #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_dep_check (
    .i_rs1        (rs1_id),
    .i_rs2        (rs2_id),
    .i_re1        (re1_id),
    .i_re2        (re2_id),
    .i_rd         (rd_id),
    .i_we         (we_id),
    .i_md_op      (md_op_id),
    .i_flush      (flush_id),
    .i_pend_valid (r_pend_valid),
    .i_pend_rd    (r_pend_rd),
    .i_busy       (md_busy),
    .o_raw        (w_raw),
    .o_waw        (w_waw),
    .o_struct     (w_struct)
  );

  // While the result waits for the port, ID is held so bubbles reach WB and
  // free a write slot within at most three cycles.
  assign w_drain  = !flush_id & (r_state == ST_WB_WAIT);
  assign stall_md = w_raw | w_waw | w_struct | w_drain;

  // pend_valid is always clear in IDLE, so only flush or a stall can block.
  assign w_issue  = (r_state == ST_IDLE) & md_op_id & !flush_id & !stall_md;

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Pipeline WB cannot stall, so it keeps the port when both collide.
        if (md_done) begin
          if (!wb_pipe_valid) begin
            w_ack       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WB_WAIT;
          end
        end
      end
      ST_WB_WAIT: begin
        if (!wb_pipe_valid) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pend_valid <= 1'b0;
      r_pend_rd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      // pend_valid stays set through the ack cycle so dependents remain
      // stalled until the write has actually happened.
      if (w_issue) begin
        r_pend_valid <= 1'b1;
        r_pend_rd    <= rd_id;
      end else if (w_ack) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  assign md_start  = w_issue;
  assign md_ack    = w_ack;
  assign wb_md_sel = w_ack;
  assign wb_md_rd  = r_pend_rd;
  assign md_busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_md_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_issue_sequencer
// Description : Self-checking bench for md_issue_sequencer. Each stimulus
//               cycle pushes its hand-computed expected outputs into a queue;
//               a monitor pops one entry per cycle and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_issue_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] rs1_id, rs2_id, rd_id;
  logic       re1_id, re2_id, we_id, md_op_id, flush_id;
  logic       wb_pipe_valid, md_done;
  logic       md_start, md_ack, wb_md_sel, stall_md, md_busy;
  logic [3:0] wb_md_rd;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic       start;
    logic       ack;
    logic       sel;
    logic [3:0] rd;
    logic       stall;
    logic       busy;
  } exp_t;

  exp_t q[$];

  md_issue_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rs1_id        (rs1_id),
    .rs2_id        (rs2_id),
    .re1_id        (re1_id),
    .re2_id        (re2_id),
    .rd_id         (rd_id),
    .we_id         (we_id),
    .md_op_id      (md_op_id),
    .flush_id      (flush_id),
    .wb_pipe_valid (wb_pipe_valid),
    .md_done       (md_done),
    .md_start      (md_start),
    .md_ack        (md_ack),
    .wb_md_sel     (wb_md_sel),
    .wb_md_rd      (wb_md_rd),
    .stall_md      (stall_md),
    .md_busy       (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s.%s: got %0d expected %0d", tag, field, act, req);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, "md_start",  int'(md_start),  int'(e.start));
      chk(e.tag, "md_ack",    int'(md_ack),    int'(e.ack));
      chk(e.tag, "wb_md_sel", int'(wb_md_sel), int'(e.sel));
      chk(e.tag, "wb_md_rd",  int'(wb_md_rd),  int'(e.rd));
      chk(e.tag, "stall_md",  int'(stall_md),  int'(e.stall));
      chk(e.tag, "md_busy",   int'(md_busy),   int'(e.busy));
    end
  end

  // Advance to just after the next rising edge and idle all ID/WB inputs.
  task automatic next();
    @(posedge clk);
    #1;
    rs1_id = 4'd0; rs2_id = 4'd0; rd_id = 4'd0;
    re1_id = 1'b0; re2_id = 1'b0; we_id = 1'b0;
    md_op_id = 1'b0; flush_id = 1'b0;
    wb_pipe_valid = 1'b0; md_done = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic start, input logic ack,
                            input logic sel, input logic [3:0] rd,
                            input logic stall, input logic busy);
    exp_t e;
    e.tag = tag; e.start = start; e.ack = ack; e.sel = sel;
    e.rd = rd; e.stall = stall; e.busy = busy;
    q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_id = 4'd0; rs2_id = 4'd0; rd_id = 4'd0;
    re1_id = 1'b0; re2_id = 1'b0; we_id = 1'b0;
    md_op_id = 1'b0; flush_id = 1'b0;
    wb_pipe_valid = 1'b0; md_done = 1'b0;

    //                       start ack sel rd     stall busy
    next();               expect_out("reset",      0, 0, 0, 4'd0,  0, 0);
    next(); rst_n = 1'b1; expect_out("post_reset", 0, 0, 0, 4'd0,  0, 0);

    // Issue rd=5, hazards while pending, done in cycle 4 with free port.
    next(); md_op_id = 1; rd_id = 5;
                          expect_out("iss_c0",     1, 0, 0, 4'd0,  0, 0);
    next(); we_id = 1; rd_id = 5;
                          expect_out("iss_waw",    0, 0, 0, 4'd5,  1, 1);
    next(); re1_id = 1; rs1_id = 5;
                          expect_out("iss_raw",    0, 0, 0, 4'd5,  1, 1);
    next(); re1_id = 1; rs1_id = 6;
                          expect_out("iss_noraw",  0, 0, 0, 4'd5,  0, 1);
    next(); re1_id = 1; rs1_id = 5; md_done = 1;
                          expect_out("iss_ack",    0, 1, 1, 4'd5,  1, 1);
    next(); re1_id = 1; rs1_id = 5;
                          expect_out("iss_after",  0, 0, 0, 4'd5,  0, 0);

    // Port conflict: done while WB busy for two cycles.
    next(); md_op_id = 1; rd_id = 7;
                          expect_out("pc_iss",     1, 0, 0, 4'd5,  0, 0);
    next();               expect_out("pc_run",     0, 0, 0, 4'd7,  0, 1);
    next(); md_done = 1; wb_pipe_valid = 1;
                          expect_out("pc_wb1",     0, 0, 0, 4'd7,  0, 1);
    next(); md_done = 1; wb_pipe_valid = 1;
                          expect_out("pc_wait",    0, 0, 0, 4'd7,  1, 1);
    next(); md_done = 1;
                          expect_out("pc_ack",     0, 1, 1, 4'd7,  1, 1);
    next();               expect_out("pc_idle",    0, 0, 0, 4'd7,  0, 0);

    // Flush in IDLE blocks the launch; flush during RUN masks the stall.
    next(); md_op_id = 1; rd_id = 9; flush_id = 1;
                          expect_out("fl_idle",    0, 0, 0, 4'd7,  0, 0);
    next();               expect_out("fl_stay",    0, 0, 0, 4'd7,  0, 0);
    next(); md_op_id = 1; rd_id = 3;
                          expect_out("fl_iss",     1, 0, 0, 4'd7,  0, 0);
    next(); re2_id = 1; rs2_id = 3; flush_id = 1;
                          expect_out("fl_run",     0, 0, 0, 4'd3,  0, 1);
    next(); re2_id = 1; rs2_id = 3;
                          expect_out("fl_raw2",    0, 0, 0, 4'd3,  1, 1);
    next(); md_done = 1;
                          expect_out("fl_ack",     0, 1, 1, 4'd3,  0, 1);
    next();               expect_out("fl_idle2",   0, 0, 0, 4'd3,  0, 0);

    // Structural: second MDU op waits until the cycle after ack.
    next(); md_op_id = 1; rd_id = 10;
                          expect_out("st_iss",     1, 0, 0, 4'd3,  0, 0);
    next(); md_op_id = 1; rd_id = 12;
                          expect_out("st_stall1",  0, 0, 0, 4'd10, 1, 1);
    next(); md_op_id = 1; rd_id = 12;
                          expect_out("st_stall2",  0, 0, 0, 4'd10, 1, 1);
    next(); md_op_id = 1; rd_id = 12; md_done = 1;
                          expect_out("st_ack",     0, 1, 1, 4'd10, 1, 1);
    next(); md_op_id = 1; rd_id = 12;
                          expect_out("st_iss2",    1, 0, 0, 4'd10, 0, 0);
    next();               expect_out("st_run2",    0, 0, 0, 4'd12, 0, 1);
    next(); md_done = 1;  expect_out("st_ack2",    0, 1, 1, 4'd12, 0, 1);
    next();               expect_out("st_idle",    0, 0, 0, 4'd12, 0, 0);

    // Reset mid-operation discards the op; a late md_done is ignored.
    next(); md_op_id = 1; rd_id = 2;
                          expect_out("rs_iss",     1, 0, 0, 4'd12, 0, 0);
    next();               expect_out("rs_run",     0, 0, 0, 4'd2,  0, 1);
    next(); re1_id = 1; rs1_id = 2; rst_n = 1'b0;
                          expect_out("rs_async",   0, 0, 0, 4'd0,  0, 0);
    next(); rst_n = 1'b1; md_done = 1;
                          expect_out("rs_done1",   0, 0, 0, 4'd0,  0, 0);
    next(); md_done = 1;  expect_out("rs_done2",   0, 0, 0, 4'd0,  0, 0);

    // Bounded drain of the scoreboard.
    begin
      int budget;
      budget = 10;
      while (q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      n_checks++;
      if (q.size() != 0) begin
        n_errors++;
        $display("FAIL drain: got %0d pending entries expected 0", q.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
